lt24_pixel_arbiter: RTL and testbench
=====================================

// Module: lt24_pixel_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single LT24Display pixel interface among NUM_REQ drawing engines.
//  Latches the winning requester's pixel, runs the display write handshake, and acks the requester.
//  Sits between the sprite/MIF drawing engines and the LT24Display pixel port.
// PARAMETERS
//  NUM_REQ      4      number of requesters, 2..8
//  X_WIDTH      8      x address width
//  Y_WIDTH      9      y address width
//  DATA_WIDTH   16     pixel colour width (RGB565)
//  TIMEOUT_CYC  1024   max cycles per display handshake phase before abort, >=2
// PORTS
//  clock       in   1                    system clock, all logic on posedge
//  reset       in   1                    asynchronous, active-high
//  req         in   NUM_REQ              req[i]=1: requester i has a pixel pending
//  lock        in   NUM_REQ              burst hold request, used only with PIXEL_ARB_LOCK_EN
//  req_x       in   NUM_REQ*X_WIDTH      requester i x at [i*X_WIDTH +: X_WIDTH]
//  req_y       in   NUM_REQ*Y_WIDTH      requester i y, same packing
//  req_data    in   NUM_REQ*DATA_WIDTH   requester i colour, same packing
//  ack         out  NUM_REQ              one-cycle pulse: requester i pixel written (or aborted)
//  grant_id    out  3                    index of last/current granted requester
//  busy        out  1                    1 while a pixel transaction is in flight
//  timeout_err out  1                    sticky: a display handshake timed out
//  disp_x      out  X_WIDTH              to LT24Display xAddr
//  disp_y      out  Y_WIDTH              to LT24Display yAddr
//  disp_data   out  DATA_WIDTH           to LT24Display pixelData
//  disp_write  out  1                    to LT24Display pixelWrite
//  disp_ready  in   1                    from LT24Display pixelReady
// BEHAVIOUR
//  Reset: ack=0, grant_id=NUM_REQ-1 (so requester 0 wins first), busy=0, timeout_err=0,
//   disp_x/y/data=0, disp_write=0, state=IDLE, timeout counter=0. Reset mid-transaction aborts it; no ack.
//  States: IDLE -> ISSUE -> WAIT_HIGH -> GAP -> IDLE.
//  IDLE: if any req: winner = first i with req[i] searching grant_id+1, +2, ... mod NUM_REQ;
//   latch winner's x/y/data into disp_*, grant_id<=winner, disp_write<=1, busy<=1, ->ISSUE. Else hold.
//  ISSUE: hold disp_write=1; on disp_ready==0 -> WAIT_HIGH, counter cleared.
//  WAIT_HIGH: on disp_ready==1: disp_write<=0, ack[grant_id]<=1 (one cycle), ->GAP.
//  GAP: one dead cycle, no arbitration (requester drops req/updates pixel here); busy<=0, ->IDLE.
//  Latency: req high in IDLE -> disp_write high next cycle; ack asserted 1 cycle after disp_ready rises.
//  Requester holds req, x, y, data stable until it sees ack; inputs sampled only in IDLE.
//  Latched disp_x/y/data stay constant for the whole transaction, independent of req_* changes.
//  Timeout: counter increments each cycle in ISSUE and WAIT_HIGH, resets on phase change; reaching
//   TIMEOUT_CYC: disp_write<=0, timeout_err<=1, ack[grant_id]<=1, ->GAP. timeout_err clears only on reset.
//  Requests dropped before grant are ignored; simultaneous requests resolved in rotation order only.
//  Only one ack bit ever high; ack never high outside the cycle after WAIT_HIGH/timeout exit.
//  A requester re-asserting req immediately after its ack loses to any other pending requester.
// CONFIGURATION
//  PIXEL_ARB_LOCK_EN defined: in IDLE, if lock[grant_id] and req[grant_id] are both 1,
//   grant_id is re-granted regardless of rotation (whole sprite drawn uninterrupted);
//   rotation resumes from grant_id once lock[grant_id] drops or req[grant_id] is 0.
//  PIXEL_ARB_LOCK_EN undefined: lock input ignored, pure per-pixel round robin.
// TESTING
//  Single req[2], x=10,y=20,data=16'hF800; model display drops ready 1 cyc, raises after 5
//   -> disp_write=1 next cycle, disp_x/y/data match, one ack[2] pulse, busy back to 0.
//  req=4'b1111 held, each acks then re-asserts -> grant order 0,1,2,3,0,1,... no double acks.
//  req[1] only, req_x changes during WAIT_HIGH -> disp_x holds original value until ack.
//  Display never drops ready, TIMEOUT_CYC=16 -> ack after 16 cycles, timeout_err=1, sticky.
//  reset asserted in WAIT_HIGH -> all outputs to reset values at once, no ack; next req(0) granted.
//  LOCK_EN build: lock[3]=1 req=4'b1001 -> requester 3 granted repeatedly; lock[3]=0 -> 0 next.

Source files
------------

// File: rtl/lt24_pixel_arbiter.sv
// Round-robin arbiter sharing one LT24Display pixel port among NUM_REQ drawing engines.
// Optional feature: define PIXEL_ARB_LOCK_EN to let a locked requester keep the port for a burst.
module lt24_pixel_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 9,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*X_WIDTH-1:0]    req_x,
  input  logic [NUM_REQ*Y_WIDTH-1:0]    req_y,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [X_WIDTH-1:0]            disp_x,
  output logic [Y_WIDTH-1:0]            disp_y,
  output logic [DATA_WIDTH-1:0]         disp_data,
  output logic                          disp_write,
  input  logic                          disp_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HIGH, GAP} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [2:0]              grant_next, winner;
  logic [3:0]              cand;
  logic [7:0]              req_ext;
  logic                    busy_next, timeout_err_next, disp_write_next;
  logic [NUM_REQ-1:0]      ack_next, ack_onehot;
  logic [X_WIDTH-1:0]      disp_x_next, win_x;
  logic [Y_WIDTH-1:0]      disp_y_next, win_y;
  logic [DATA_WIDTH-1:0]   disp_data_next, win_data;
  logic                    timeout_hit;

  assign req_ext     = 8'(req);
  assign ack_onehot  = NUM_REQ'(1) << grant_id;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef PIXEL_ARB_LOCK_EN
  logic [7:0] lock_ext;
  assign lock_ext = 8'(lock);
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Rotating search starting just after the last grant; the last grantee is tried last.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    winner = grant_id;
    cand   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = {1'b0, grant_id} + 4'(off);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (req_ext[cand[2:0]]) winner = cand[2:0];
    end
`ifdef PIXEL_ARB_LOCK_EN
    if (req_ext[grant_id] && lock_ext[grant_id]) winner = grant_id;
`endif
  end

  always_comb begin
    win_x    = '0;
    win_y    = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) begin
        win_x    = req_x[i*X_WIDTH +: X_WIDTH];
        win_y    = req_y[i*Y_WIDTH +: Y_WIDTH];
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    grant_next       = grant_id;
    busy_next        = busy;
    timeout_err_next = timeout_err;
    disp_x_next      = disp_x;
    disp_y_next      = disp_y;
    disp_data_next   = disp_data;
    disp_write_next  = disp_write;
    ack_next         = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_next      = winner;
          disp_x_next     = win_x;
          disp_y_next     = win_y;
          disp_data_next  = win_data;
          disp_write_next = 1'b1;
          busy_next       = 1'b1;
          cnt_next        = '0;
          state_next      = ISSUE;
        end
      end
      ISSUE, WAIT_HIGH: begin
        if ((state == ISSUE) ? !disp_ready : disp_ready) begin
          cnt_next = '0;
          if (state == ISSUE) begin
            state_next = WAIT_HIGH;
          end else begin
            disp_write_next = 1'b0;
            ack_next        = ack_onehot;
            state_next      = GAP;
          end
        end else if (timeout_hit) begin
          // Abandon the pixel but still release the requester so it cannot stall.
          disp_write_next  = 1'b0;
          timeout_err_next = 1'b1;
          ack_next         = ack_onehot;
          cnt_next         = '0;
          state_next       = GAP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GAP: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      grant_id    <= 3'(NUM_REQ - 1);
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      disp_x      <= '0;
      disp_y      <= '0;
      disp_data   <= '0;
      disp_write  <= 1'b0;
      ack         <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      grant_id    <= grant_next;
      busy        <= busy_next;
      timeout_err <= timeout_err_next;
      disp_x      <= disp_x_next;
      disp_y      <= disp_y_next;
      disp_data   <= disp_data_next;
      disp_write  <= disp_write_next;
      ack         <= ack_next;
    end
  end

endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Directed bench for lt24_pixel_arbiter with a small LT24 pixel-handshake model.
// Honours PIXEL_ARB_LOCK_EN when the build defines it.
module tb_lt24_pixel_arbiter;

  localparam int NR = 4;
  localparam int XW = 8;
  localparam int YW = 9;
  localparam int DW = 16;
  localparam int TO = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     lock = '0;
  logic [NR*XW-1:0]  req_x = '0;
  logic [NR*YW-1:0]  req_y = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     ack;
  logic [2:0]        grant_id;
  logic              busy, timeout_err, disp_write;
  logic [XW-1:0]     disp_x;
  logic [YW-1:0]     disp_y;
  logic [DW-1:0]     disp_data;
  logic              disp_ready;
  logic              never_drop = 1'b0;

  int tests  = 0;
  int failed = 0;

  lt24_pixel_arbiter #(
    .NUM_REQ(NR), .X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock),
    .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
    .disp_x(disp_x), .disp_y(disp_y), .disp_data(disp_data),
    .disp_write(disp_write), .disp_ready(disp_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Display model: drop ready the cycle after a write appears, raise it 5 cycles later.
  initial begin
    disp_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (disp_write && disp_ready && !never_drop) begin
        disp_ready = 1'b0;
        repeat (5) @(negedge clock);
        disp_ready = 1'b1;
        for (int k = 0; k < 50 && disp_write; k++) @(negedge clock);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_pixel(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [DW-1:0] d);
    req_x[i*XW +: XW]    = x;
    req_y[i*YW +: YW]    = y;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic wait_ack(output logic [NR-1:0] a, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ack == '0 && n < 200);
    a = ack;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  logic [NR-1:0] a;
  int            n;
  logic [NR-1:0] acc;
  int            rr_exp[6];
  int            lk_exp[6];

  initial begin
    rr_exp = '{0, 1, 2, 3, 0, 1};
`ifdef PIXEL_ARB_LOCK_EN
    lk_exp = '{3, 3, 3, 0, 3, 0};
`else
    lk_exp = '{0, 3, 0, 3, 0, 3};
`endif

    // Reset values
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ack", ack, 0);
    check("rst_grant", grant_id, 3);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_write", disp_write, 0);
    check("rst_xydata", {disp_x, disp_y, disp_data}, 0);

    // Single requester 2
    set_pixel(2, 8'd10, 9'd20, 16'hF800);
    req = 4'b0100;
    @(negedge clock);
    check("single_write", disp_write, 1);
    check("single_busy", busy, 1);
    check("single_grant", grant_id, 2);
    check("single_x", disp_x, 10);
    check("single_y", disp_y, 20);
    check("single_data", disp_data, 16'hF800);
    wait_ack(a, n);
    check("single_ack", a, 4'b0100);
    check("single_write_low", disp_write, 0);
    check("single_ack_lat", n, 6);
    req = '0;
    @(negedge clock);
    check("single_ack_clear", ack, 0);
    check("single_busy_low", busy, 0);
    check("single_terr", timeout_err, 0);

    // Round robin with all requesters held
    do_reset();
    for (int i = 0; i < NR; i++) set_pixel(i, 8'(8'h10 + i), 9'(i), 16'(16'hA000 + i));
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(a, n);
      check("rr_ack", a, 32'(1) << rr_exp[k]);
      check("rr_grant", grant_id, rr_exp[k]);
      check("rr_x", disp_x, 8'h10 + rr_exp[k]);
      if (k == 5) req = '0;
      @(negedge clock);
      check("rr_ack_clear", ack, 0);
    end
    repeat (3) @(negedge clock);

    // Latched pixel stays constant while requester inputs move
    set_pixel(1, 8'd33, 9'd44, 16'h1234);
    req = 4'b0010;
    @(negedge clock);
    check("hold_write", disp_write, 1);
    check("hold_x0", disp_x, 33);
    @(negedge clock);
    set_pixel(1, 8'd77, 9'd88, 16'h5678);
    wait_ack(a, n);
    check("hold_ack", a, 4'b0010);
    check("hold_x", disp_x, 33);
    check("hold_y", disp_y, 44);
    check("hold_data", disp_data, 16'h1234);
    req = '0;
    repeat (2) @(negedge clock);

    // Display never drops ready: abort after TIMEOUT_CYC cycles
    never_drop = 1'b1;
    set_pixel(0, 8'd5, 9'd6, 16'h0007);
    req = 4'b0001;
    @(negedge clock);
    check("to_write", disp_write, 1);
    check("to_terr_before", timeout_err, 0);
    wait_ack(a, n);
    check("to_cycles", n, TO);
    check("to_ack", a, 4'b0001);
    check("to_terr", timeout_err, 1);
    check("to_write_low", disp_write, 0);
    req = '0;
    never_drop = 1'b0;
    repeat (3) @(negedge clock);
    check("to_sticky_idle", timeout_err, 1);
    set_pixel(2, 8'd1, 9'd2, 16'h0003);
    req = 4'b0100;
    wait_ack(a, n);
    check("to_next_ack", a, 4'b0100);
    check("to_sticky_after", timeout_err, 1);
    req = '0;
    repeat (2) @(negedge clock);

    // Reset during WAIT_HIGH
    set_pixel(2, 8'd9, 9'd9, 16'h0009);
    req = 4'b0100;
    @(negedge clock);
    @(negedge clock);
    check("rw_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("rw_ack", ack, 0);
    check("rw_grant", grant_id, 3);
    check("rw_busy", busy, 0);
    check("rw_terr", timeout_err, 0);
    check("rw_write", disp_write, 0);
    check("rw_xydata", {disp_x, disp_y, disp_data}, 0);
    acc = '0;
    repeat (6) begin
      @(negedge clock);
      acc = acc | ack;
    end
    check("rw_no_ack", acc, 0);
    reset = 1'b0;
    set_pixel(0, 8'h21, 9'd1, 16'h0021);
    set_pixel(2, 8'h23, 9'd3, 16'h0023);
    req = 4'b0101;
    @(negedge clock);
    check("rw_next_grant", grant_id, 0);
    check("rw_next_write", disp_write, 1);
    check("rw_next_x", disp_x, 8'h21);
    wait_ack(a, n);
    check("rw_next_ack0", a, 4'b0001);
    req = 4'b0100;
    @(negedge clock);
    wait_ack(a, n);
    check("rw_next_ack2", a, 4'b0100);
    check("rw_next_grant2", grant_id, 2);
    req = '0;
    repeat (3) @(negedge clock);

    // Lock on requester 3 (honoured only in the lock build)
    do_reset();
    set_pixel(0, 8'h40, 9'd0, 16'h0040);
    set_pixel(3, 8'h43, 9'd3, 16'h0043);
    lock = 4'b1000;
    req  = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      wait_ack(a, n);
      check("lock_ack", a, 32'(1) << lk_exp[k]);
      check("lock_grant", grant_id, lk_exp[k]);
      if (k == 2) lock = '0;
      if (k == 5) req = '0;
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    check("end_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
